// File: rtl/logic_exec_stage_pkg.sv
// Shared definitions for the logic execution stage.
// Holds the opcode encodings and the default operand/result width used by
// the stage and its sub-modules.
package logic_exec_stage_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_NOR = 2'b10,
        OP_INV = 2'b11
    } opcode_e;

endpackage

// File: rtl/logic_and32.sv
// Bitwise AND of two operands.
// Ports: a, b - operands; y - a & b.
module logic_and32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a & b;
endmodule

// File: rtl/logic_inv32.sv
// Bitwise inverter.
// Ports: a - operand; y - ~a.
module logic_inv32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);
    assign y = ~a;
endmodule

// File: rtl/logic_nor32.sv
// Bitwise NOR of two operands.
// Ports: a, b - operands; y - ~(a | b).
module logic_nor32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = ~(a | b);
endmodule

// File: rtl/logic_or32.sv
// Bitwise OR of two operands.
// Ports: a, b - operands; y - a | b.
module logic_or32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = a | b;
endmodule

// File: rtl/logic_result_fifo.sv
// Result buffer for the logic execution stage: a DEPTH-entry circular FIFO
// with registered head data, valid and ready outputs.
// Ports: clk, rst_n (async active-low); wr_en/wr_data/wr_ready - write side;
//        rd_en/rd_valid/rd_data - read side (rd_data is 0 while empty).
module logic_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_en,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             wr_ready_r;
    logic             rd_valid_r;
    logic [WIDTH-1:0] rd_data_r;

    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [PTR_W:0]   count_next_s;
    logic [WIDTH-1:0] head_next_s;

    // Transfers are qualified by the registered handshake outputs, so a full
    // buffer never accepts in the same cycle it pops.
    assign push_s = wr_en & wr_ready_r;
    assign pop_s  = rd_en & rd_valid_r;

    // Next pointers, occupancy and head entry as seen after this edge.
    always_comb begin
        wr_ptr_next_s = wr_ptr_r;
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        head_next_s   = {WIDTH{1'b0}};
        if (push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (PTR_W+1)'(1);
            2'b01:   count_next_s = count_r - (PTR_W+1)'(1);
            default: count_next_s = count_r;
        endcase
        // The slot being written this edge becomes the head only when it is
        // the sole remaining entry; the memory write is not yet visible.
        if (count_next_s == {(PTR_W+1){1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = wr_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage array; stale contents are harmless because count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy and registered outputs; reset discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            wr_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_r   <= wr_ptr_next_s;
            rd_ptr_r   <= rd_ptr_next_s;
            count_r    <= count_next_s;
            wr_ready_r <= (count_next_s < DEPTH_C);
            rd_valid_r <= (count_next_s != {(PTR_W+1){1'b0}});
            rd_data_r  <= head_next_s;
        end
    end

    assign wr_ready = wr_ready_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
endmodule

// File: rtl/logic_exec_stage.sv
// Logic execution stage: computes AND/OR/NOR/INV(A) on accepted operand sets,
// buffers result plus zero flag, and delivers them downstream in order.
// Ports: CLK, RST (async active-low); IN_VALID/IN_READY/OPCODE/A/B - operand
//        input; OUT_VALID/OUT_READY/Y/ZERO - head result output;
//        OP_COUNT - number of results delivered (wraps at 16 bits).
module logic_exec_stage
    import logic_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [1:0]            OPCODE,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] Y,
    output logic                  ZERO,
    output logic [15:0]           OP_COUNT
);
    logic [DATA_WIDTH-1:0] and_s;
    logic [DATA_WIDTH-1:0] or_s;
    logic [DATA_WIDTH-1:0] nor_s;
    logic [DATA_WIDTH-1:0] inv_s;
    logic [DATA_WIDTH-1:0] result_s;
    logic                  zero_s;
    logic [DATA_WIDTH:0]   head_s;
    logic                  fifo_ready_s;
    logic                  fifo_valid_s;
    logic [15:0]           op_count_r;

    logic_and32 #(.WIDTH(DATA_WIDTH)) u_and (.a(A), .b(B), .y(and_s));
    logic_or32  #(.WIDTH(DATA_WIDTH)) u_or  (.a(A), .b(B), .y(or_s));
    logic_nor32 #(.WIDTH(DATA_WIDTH)) u_nor (.a(A), .b(B), .y(nor_s));
    logic_inv32 #(.WIDTH(DATA_WIDTH)) u_inv (.a(A), .y(inv_s));

    // 4:1 result mux and zero detect.
    always_comb begin
        result_s = {DATA_WIDTH{1'b0}};
        case (OPCODE)
            OP_AND:  result_s = and_s;
            OP_OR:   result_s = or_s;
            OP_NOR:  result_s = nor_s;
            OP_INV:  result_s = inv_s;
            default: result_s = {DATA_WIDTH{1'b0}};
        endcase
        zero_s = (result_s == {DATA_WIDTH{1'b0}});
    end

    logic_result_fifo #(
        .WIDTH(DATA_WIDTH + 1),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst_n    (RST),
        .wr_en    (IN_VALID),
        .wr_data  ({zero_s, result_s}),
        .wr_ready (fifo_ready_s),
        .rd_en    (OUT_READY),
        .rd_valid (fifo_valid_s),
        .rd_data  (head_s)
    );

    // Delivered-result counter; wraps silently.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_count_r <= 16'd0;
        end else if (fifo_valid_s && OUT_READY) begin
            op_count_r <= op_count_r + 16'd1;
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign IN_READY  = fifo_ready_s;
    assign OUT_VALID = fifo_valid_s;
    assign Y         = head_s[DATA_WIDTH-1:0];
    assign ZERO      = head_s[DATA_WIDTH];
    assign OP_COUNT  = op_count_r;
endmodule

// File: tb/tb_logic_exec_stage.sv
module tb_logic_exec_stage;
    logic        CLK;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  OPCODE;
    logic [31:0] A;
    logic [31:0] B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] Y;
    logic        ZERO;
    logic [15:0] OP_COUNT;

    int pass_cnt;
    int check_cnt;

    logic_exec_stage #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPCODE(OPCODE), .A(A), .B(B), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .Y(Y), .ZERO(ZERO), .OP_COUNT(OP_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        IN_VALID = 1'b1; OPCODE = op; A = a; B = b;
        tick();
        IN_VALID = 1'b0;
    endtask

    task automatic pop_one();
        OUT_READY = 1'b1;
        tick();
        OUT_READY = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        #3;
        @(negedge CLK);
        RST = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        OPCODE = 2'b00; A = 32'h0; B = 32'h0;
        #1;
        check_cnt++;
        if ({IN_READY, OUT_VALID, ZERO} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {IN_READY, OUT_VALID, ZERO});
        else pass_cnt++;
        check_cnt++;
        if (Y !== 32'h0 || OP_COUNT !== 16'h0) $display("FAIL reset_data: got Y=%h cnt=%h expected 0/0", Y, OP_COUNT);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        check_cnt++;
        if (IN_READY !== 1'b1) $display("FAIL reset_ready_return: got %b expected 1", IN_READY);
        else pass_cnt++;
    endtask

    task automatic test_single_and();
        push_one(2'b00, 32'hF0F0F0F0, 32'hFF00FF00);
        check_cnt++;
        if (OUT_VALID !== 1'b1 || Y !== 32'hF000F000 || ZERO !== 1'b0)
            $display("FAIL and_result: got v=%b Y=%h Z=%b expected 1/F000F000/0", OUT_VALID, Y, ZERO);
        else pass_cnt++;
        pop_one();
        check_cnt++;
        if (OUT_VALID !== 1'b0 || Y !== 32'h0 || OP_COUNT !== 16'd1)
            $display("FAIL and_pop: got v=%b Y=%h cnt=%0d expected 0/0/1", OUT_VALID, Y, OP_COUNT);
        else pass_cnt++;
    endtask

    task automatic test_nor_inv();
        push_one(2'b10, 32'hFFFFFFFF, 32'h00000000);
        check_cnt++;
        if (Y !== 32'h0 || ZERO !== 1'b1 || OUT_VALID !== 1'b1)
            $display("FAIL nor_result: got Y=%h Z=%b v=%b expected 0/1/1", Y, ZERO, OUT_VALID);
        else pass_cnt++;
        push_one(2'b11, 32'h0000FFFF, 32'h12345678);
        // Head must hold while OUT_READY=0, and idle input changes are ignored.
        OPCODE = 2'b01; A = 32'hAAAAAAAA; B = 32'h55555555;
        tick();
        check_cnt++;
        if (Y !== 32'h0 || ZERO !== 1'b1) $display("FAIL nor_hold: got Y=%h Z=%b expected 0/1", Y, ZERO);
        else pass_cnt++;
        pop_one();
        check_cnt++;
        if (Y !== 32'hFFFF0000 || ZERO !== 1'b0) $display("FAIL inv_result: got Y=%h Z=%b expected FFFF0000/0", Y, ZERO);
        else pass_cnt++;
        pop_one();
        check_cnt++;
        if (OUT_VALID !== 1'b0 || OP_COUNT !== 16'd3) $display("FAIL nor_inv_drain: got v=%b cnt=%0d expected 0/3", OUT_VALID, OP_COUNT);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        logic [31:0] fa [4];
        logic [31:0] fb [4];
        logic [31:0] fy [4];
        fa = '{32'h00000001, 32'h00000010, 32'h00000100, 32'h00001000};
        fb = '{32'h10000000, 32'h01000000, 32'h00100000, 32'h00010000};
        fy = '{32'h10000001, 32'h01000010, 32'h00100100, 32'h00011000};
        for (int i = 0; i < 4; i++) begin
            push_one(2'b01, fa[i], fb[i]);
            check_cnt++;
            if (IN_READY !== (i < 3)) $display("FAIL fill_ready_%0d: got %b expected %b", i, IN_READY, (i < 3));
            else pass_cnt++;
        end
        push_one(2'b01, 32'hDEADBEEF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (Y !== fy[i] || OUT_VALID !== 1'b1) $display("FAIL fill_order_%0d: got Y=%h v=%b expected %h/1", i, Y, OUT_VALID, fy[i]);
            else pass_cnt++;
            pop_one();
            if (i == 0) begin
                check_cnt++;
                if (IN_READY !== 1'b1) $display("FAIL fill_ready_after_pop: got %b expected 1", IN_READY);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (OUT_VALID !== 1'b0 || OP_COUNT !== 16'd7) $display("FAIL fill_drained: got v=%b cnt=%0d expected 0/7", OUT_VALID, OP_COUNT);
        else pass_cnt++;
    endtask

    task automatic test_streaming();
        int errs;
        do_reset();
        push_one(2'b01, 32'h00000000, 32'hA5A50000);
        errs = 0;
        IN_VALID = 1'b1; OUT_READY = 1'b1; OPCODE = 2'b01; B = 32'hA5A50000;
        for (int k = 0; k < 10; k++) begin
            A = {24'h0, 8'(k + 1)};
            if (Y !== {24'hA5A500, 8'(k)} || OUT_VALID !== 1'b1) errs++;
            tick();
            if (IN_READY !== 1'b1 || OUT_VALID !== 1'b1) errs++;
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        check_cnt++;
        if (errs != 0) $display("FAIL stream_order: got %0d bad cycles expected 0", errs);
        else pass_cnt++;
        check_cnt++;
        if (OP_COUNT !== 16'd10 || Y !== 32'hA5A5000A) $display("FAIL stream_count: got cnt=%0d Y=%h expected 10/A5A5000A", OP_COUNT, Y);
        else pass_cnt++;
        pop_one();
        check_cnt++;
        if (OUT_VALID !== 1'b0) $display("FAIL stream_empty: got %b expected 0", OUT_VALID);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stream();
        push_one(2'b00, 32'hFFFFFFFF, 32'h11111111);
        push_one(2'b00, 32'hFFFFFFFF, 32'h22222222);
        push_one(2'b00, 32'hFFFFFFFF, 32'h33333333);
        check_cnt++;
        if (OUT_VALID !== 1'b1 || Y !== 32'h11111111 || OP_COUNT !== 16'd11)
            $display("FAIL midrst_pre: got v=%b Y=%h cnt=%0d expected 1/11111111/11", OUT_VALID, Y, OP_COUNT);
        else pass_cnt++;
        #2;
        RST = 1'b0;
        #1;
        check_cnt++;
        if (OUT_VALID !== 1'b0 || Y !== 32'h0 || OP_COUNT !== 16'd0 || IN_READY !== 1'b0)
            $display("FAIL midrst_clear: got v=%b Y=%h cnt=%0d rdy=%b expected 0/0/0/0", OUT_VALID, Y, OP_COUNT, IN_READY);
        else pass_cnt++;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        check_cnt++;
        if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) $display("FAIL midrst_after: got rdy=%b v=%b expected 1/0", IN_READY, OUT_VALID);
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        push_one(2'b01, 32'h1, 32'h0);
        IN_VALID = 1'b1; OUT_READY = 1'b1;
        for (int k = 0; k < 65534; k++) tick();
        IN_VALID = 1'b0;
        tick();
        OUT_READY = 1'b0;
        check_cnt++;
        if (OP_COUNT !== 16'hFFFF || OUT_VALID !== 1'b0) $display("FAIL wrap_max: got cnt=%h v=%b expected FFFF/0", OP_COUNT, OUT_VALID);
        else pass_cnt++;
        push_one(2'b01, 32'h1, 32'h0);
        pop_one();
        check_cnt++;
        if (OP_COUNT !== 16'h0000) $display("FAIL wrap_zero: got %h expected 0000", OP_COUNT);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        check_cnt = 0;
        test_reset();
        test_single_and();
        test_nor_inv();
        test_fill();
        test_streaming();
        test_reset_mid_stream();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
